// File: rtl/bus_pkg.sv
// Shared definitions for the CPU datapath bus: source index map and sizing helpers.
package bus_pkg;

    localparam int R0     = 0;
    localparam int R1     = 1;
    localparam int R2     = 2;
    localparam int R3     = 3;
    localparam int R4     = 4;
    localparam int R5     = 5;
    localparam int R6     = 6;
    localparam int R7     = 7;
    localparam int R8     = 8;
    localparam int R9     = 9;
    localparam int R10    = 10;
    localparam int R11    = 11;
    localparam int R12    = 12;
    localparam int R13    = 13;
    localparam int R14    = 14;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int CSIGN  = 23;

    localparam int N_SRC_DEFAULT = 24;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational priority encoder: lowest set bit wins, plus any-set and multi-set flags.
module prio_enc_n
    import bus_pkg::*;
#(
    parameter int N = N_SRC_DEFAULT
) (
    input  logic [N-1:0]          req,
    output logic [sel_w(N)-1:0]   idx,
    output logic                  any,
    output logic                  multi
);

    localparam int SELW = sel_w(N);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned (no latch); blocking '=' lets later iterations see earlier ones.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    idx = SELW'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arb_n.sv
// Registered N-source datapath bus with priority select, idle hold/zero,
// sticky multi-driver flag, saturating conflict counter and last-source index.
module bus_arb_n
    import bus_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = N_SRC_DEFAULT,
    parameter int HOLD  = 1,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [N*WIDTH-1:0]   src_data,
    input  logic [N-1:0]         src_out,
    input  logic                 conflict_clr,
    output logic [WIDTH-1:0]     bus_data,
    output logic [sel_w(N)-1:0]  bus_sel,
    output logic                 bus_valid,
    output logic                 conflict,
    output logic [CNTW-1:0]      conflict_cnt
);

    localparam int SELW = sel_w(N);

    logic [WIDTH-1:0] src_arr [N];
    logic [SELW-1:0]  win_idx;
    logic             win_any;
    logic             win_multi;
    logic [WIDTH-1:0] win_data;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
    end

    prio_enc_n #(.N(N)) u_enc (
        .req   (src_out),
        .idx   (win_idx),
        .any   (win_any),
        .multi (win_multi)
    );

    assign win_data = src_arr[win_idx];

    // NOTE: state registers use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            bus_data     <= '0;
            bus_sel      <= '0;
            bus_valid    <= 1'b0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (win_any) begin
                bus_data  <= win_data;
                bus_sel   <= win_idx;
                bus_valid <= 1'b1;
            end else begin
                bus_valid <= 1'b0;
                if (HOLD == 0) begin
                    bus_data <= '0;
                end
            end

            // A clear request beats a conflict on the same edge; that conflict is dropped.
            if (conflict_clr) begin
                conflict     <= 1'b0;
                conflict_cnt <= '0;
            end else if (win_multi) begin
                conflict <= 1'b1;
                if (conflict_cnt != '1) begin
                    conflict_cnt <= conflict_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_n.sv
// Self-checking bench: two bus_arb_n configurations against a spec-level model.
module tb_bus_arb_n;
    import bus_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          sel;
        bit          valid;
        bit          conflict;
        int          cnt;
    } st_t;

    logic clk = 1'b0;
    logic clear;
    logic conflict_clr;

    // Configuration A: defaults (N=24, WIDTH=32, HOLD=1, CNTW=8)
    logic [24*32-1:0] a_src_data;
    logic [23:0]      a_en;
    logic [31:0]      a_w [24];
    logic [31:0]      a_bus_data;
    logic [4:0]       a_bus_sel;
    logic             a_valid, a_conf;
    logic [7:0]       a_cnt;

    // Configuration B: N=5, WIDTH=8, HOLD=0, CNTW=3
    logic [5*8-1:0]   b_src_data;
    logic [4:0]       b_en;
    logic [31:0]      b_w [24];
    logic [7:0]       b_bus_data;
    logic [2:0]       b_bus_sel;
    logic             b_valid, b_conf;
    logic [2:0]       b_cnt;

    st_t sa, sb;
    int  checks = 0;
    int  failures = 0;
    bit  cmp_en = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 24; i++) a_src_data[i*32 +: 32] = a_w[i];
        for (int i = 0; i < 5; i++)  b_src_data[i*8 +: 8]   = b_w[i][7:0];
    end

    bus_arb_n u_a (
        .clk(clk), .clear(clear), .src_data(a_src_data), .src_out(a_en),
        .conflict_clr(conflict_clr), .bus_data(a_bus_data), .bus_sel(a_bus_sel),
        .bus_valid(a_valid), .conflict(a_conf), .conflict_cnt(a_cnt)
    );

    bus_arb_n #(.WIDTH(8), .N(5), .HOLD(0), .CNTW(3)) u_b (
        .clk(clk), .clear(clear), .src_data(b_src_data), .src_out(b_en),
        .conflict_clr(conflict_clr), .bus_data(b_bus_data), .bus_sel(b_bus_sel),
        .bus_valid(b_valid), .conflict(b_conf), .conflict_cnt(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state of the bus as described behaviourally: lowest enabled source wins.
    function automatic st_t model_next(input st_t s, input logic [31:0] w [24],
                                       input logic [23:0] en, input int n, input bit hold,
                                       input int cmax, input bit clr_all, input bit cclr);
        st_t r;
        int  k;
        int  pop;
        r = s;
        if (clr_all) begin
            r.data = 0; r.sel = 0; r.valid = 0; r.conflict = 0; r.cnt = 0;
            return r;
        end
        k = -1;
        pop = 0;
        for (int i = 0; i < n; i++) begin
            if (en[i]) begin
                pop++;
                if (k < 0) k = i;
            end
        end
        if (k >= 0) begin
            r.data = w[k]; r.sel = k; r.valid = 1;
        end else begin
            r.valid = 0;
            if (!hold) r.data = 0;
        end
        if (cclr) begin
            r.conflict = 0; r.cnt = 0;
        end else if (pop >= 2) begin
            r.conflict = 1;
            r.cnt = (s.cnt >= cmax) ? cmax : s.cnt + 1;
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        sa = model_next(sa, a_w, a_en, 24, 1'b1, 255, clear, conflict_clr);
        sb = model_next(sb, b_w, {19'd0, b_en}, 5, 1'b0, 7, clear, conflict_clr);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_data",  a_bus_data, sa.data);
            check("a_sel",   32'(a_bus_sel), sa.sel);
            check("a_valid", 32'(a_valid), 32'(sa.valid));
            check("a_conf",  32'(a_conf), 32'(sa.conflict));
            check("a_cnt",   32'(a_cnt), sa.cnt);
            check("b_data",  32'(b_bus_data), sb.data);
            check("b_sel",   32'(b_bus_sel), sb.sel);
            check("b_valid", 32'(b_valid), 32'(sb.valid));
            check("b_conf",  32'(b_conf), 32'(sb.conflict));
            check("b_cnt",   32'(b_cnt), sb.cnt);
        end
    end

    initial begin
        sa = '{data: 0, sel: 0, valid: 0, conflict: 0, cnt: 0};
        sb = sa;
        clear = 1'b1;
        conflict_clr = 1'b0;
        a_en = '1;
        b_en = '1;
        for (int i = 0; i < 24; i++) begin
            a_w[i] = $urandom;
            b_w[i] = 32'($urandom_range(0, 255));
        end

        // Reset with every enable asserted
        cycle();
        cmp_en = 1;
        cycle();
        check("rst_a_data",  a_bus_data, 0);
        check("rst_a_sel",   32'(a_bus_sel), 0);
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_a_conf",  32'(a_conf), 0);
        check("rst_a_cnt",   32'(a_cnt), 0);
        check("rst_b_data",  32'(b_bus_data), 0);
        clear = 1'b0;
        a_en = '0;
        b_en = '0;

        // Single source MDR
        a_w[MDR] = 32'hDEADBEEF;
        a_en = 24'd1 << MDR;
        cycle();
        check("mdr_data",  a_bus_data, 32'hDEADBEEF);
        check("mdr_sel",   32'(a_bus_sel), 21);
        check("mdr_valid", 32'(a_valid), 1);
        check("mdr_conf",  32'(a_conf), 0);

        // Capture PC (A) and source 2 (B), then go idle
        a_w[PC] = 32'h10;
        a_en = 24'd1 << PC;
        b_w[2] = 32'h10;
        b_en = 5'b00100;
        cycle();
        a_en = '0;
        b_en = '0;
        cycle();
        check("idle_hold_data",  a_bus_data, 32'h10);
        check("idle_hold_valid", 32'(a_valid), 0);
        check("idle_hold_sel",   32'(a_bus_sel), 20);
        check("idle_zero_data",  32'(b_bus_data), 0);
        check("idle_zero_valid", 32'(b_valid), 0);
        check("idle_zero_sel",   32'(b_bus_sel), 2);

        // Two-hot conflict R3 + HI, then saturate over 300 cycles
        a_w[R3] = 32'h5;
        a_w[HI] = 32'h9;
        a_en = (24'd1 << R3) | (24'd1 << HI);
        cycle();
        check("conf_data", a_bus_data, 32'h5);
        check("conf_sel",  32'(a_bus_sel), 3);
        check("conf_flag", 32'(a_conf), 1);
        check("conf_cnt",  32'(a_cnt), 1);
        repeat (299) cycle();
        check("sat_cnt",  32'(a_cnt), 255);
        check("sat_flag", 32'(a_conf), 1);

        // Clear request coinciding with a conflict
        a_w[R3] = 32'h77;
        a_en = (24'd1 << R3) | (24'd1 << R5);
        conflict_clr = 1'b1;
        cycle();
        check("clr_cnt",  32'(a_cnt), 0);
        check("clr_flag", 32'(a_conf), 0);
        check("clr_data", a_bus_data, 32'h77);
        conflict_clr = 1'b0;
        a_en = '0;

        // Walk one-hot enables on the 5-source instance, back to back
        for (int i = 0; i < 5; i++) begin
            b_w[i] = 32'(17 * (i + 1));
            b_en = 5'd1 << i;
            cycle();
            check("walk_data", 32'(b_bus_data), 32'(17 * (i + 1)));
            check("walk_sel",  32'(b_bus_sel), i);
        end
        b_en = '0;

        // Clear mid-stream, then first capture on the following edge
        a_w[R7] = 32'hCAFE;
        a_en = 24'd1 << R7;
        clear = 1'b1;
        cycle();
        check("midclr_data",  a_bus_data, 0);
        check("midclr_valid", 32'(a_valid), 0);
        clear = 1'b0;
        cycle();
        check("postclr_data", a_bus_data, 32'hCAFE);
        check("postclr_sel",  32'(a_bus_sel), 7);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int mode;
            for (int i = 0; i < 24; i++) begin
                a_w[i] = $urandom;
                b_w[i] = 32'($urandom_range(0, 255));
            end
            mode = $urandom_range(0, 9);
            if (mode < 2)      a_en = '0;
            else if (mode < 7) a_en = 24'd1 << $urandom_range(0, 23);
            else               a_en = 24'($urandom & $urandom);
            mode = $urandom_range(0, 9);
            if (mode < 2)      b_en = '0;
            else if (mode < 6) b_en = 5'd1 << $urandom_range(0, 4);
            else               b_en = 5'($urandom);
            conflict_clr = ($urandom_range(0, 39) == 0);
            clear        = ($urandom_range(0, 99) == 0);
            cycle();
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arb_n.md
# bus_arb_n

Parametrised, registered datapath bus for the CPU: N source registers with one-hot drive enables, a built-in priority encoder, and a one-cycle registered bus output. It generalises the 24-source, 32-bit combinational bus to any width and source count. It adds hold-or-zero idle behaviour, multiple-driver detection with a sticky flag and saturating conflict counter, and a last-source register for debug. It sits between the register file/special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

## Interface
- WIDTH, 32, data width of every source and of the bus
- N, 24, number of sources (≥2)
- HOLD, 1, 1 = bus holds last value when no source enabled; 0 = bus drives zero
- CNTW, 8, width of conflict counter
- clk  in  1  clock, all state updates on rising edge
- clear  in  1  reset; one clock, synchronous, active-high
- src_data  in  N*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- src_out  in  N  drive enables, intended one-hot (bit i = source i out)
- conflict_clr  in  1  clears conflict flag and counter
- bus_data  out  WIDTH  registered bus value
- bus_sel  out  SELW = $clog2(N)  index of source captured last edge
- bus_valid  out  1  1 = a source was enabled at last edge
- conflict  out  1  sticky: ≥2 enables seen in one cycle
- conflict_cnt  out  CNTW  saturating count of conflict cycles

## Operation
- Each edge: k = lowest set index of src_out (priority to lower index, R0 highest).
- If src_out ≠ 0: bus_data ← src_data[k], bus_sel ← k, bus_valid ← 1.
- If src_out == 0: bus_valid ← 0, bus_sel holds; bus_data holds (HOLD=1) or ← 0 (HOLD=0).
- Multi-driver (popcount(src_out) ≥ 2): data still taken from lowest index; conflict ← 1; conflict_cnt += 1, saturating at 2^CNTW−1 (no wrap).
- conflict_clr: conflict ← 0, conflict_cnt ← 0. If a conflict occurs in the same cycle, clr wins for that edge; the conflict is not counted.
- clear: bus_data ← 0, bus_sel ← 0, bus_valid ← 0, conflict ← 0, conflict_cnt ← 0; overrides all inputs in that cycle.
- Enables with index ≥ N do not exist; bus_sel never exceeds N−1.
- No handshake: sources must hold data and enable through the capturing edge.

## Timing
- Latency: exactly 1 cycle from src_out/src_data sampled to bus_data/bus_sel/bus_valid visible.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back different sources on consecutive cycles give consecutive bus values with no bubble.
- conflict/conflict_cnt update on the same edge as the corresponding bus_data.
- Reset values: all outputs 0.
- Clear asserted mid-stream: the next edge yields zeros. The first valid capture follows on the edge after clear deasserts.

## Structure
- Shared package bus_pkg:
  - source index constants R0..R15 = 0..15, HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INPORT = 22, CSIGN = 23
  - N_SRC_DEFAULT = 24
  - function sel_w(n) = $clog2(n)
- Sub-module prio_enc_n:
  - parameter N; combinational
  - outputs: index of lowest set bit, any-set flag, multi-set flag
  - Instantiated once, which keeps the top block to the capture registers and counter.

## Test plan
- Reset: apply clear for 2 cycles with src_out = all-ones. Every output reads 0 and conflict_cnt = 0.
- Single source: src_out = 1<<21 (MDR), MDR data = 0xDEADBEEF. Next cycle: bus_data = 0xDEADBEEF, bus_sel = 21, bus_valid = 1, conflict = 0.
- Idle: after PC = 0x00000010 is captured, drive src_out = 0.
  - HOLD=1: bus_data stays 0x00000010, bus_valid = 0.
  - HOLD=0: bus_data = 0.
- Conflict: src_out = (1<<3)|(1<<16), R3 = 0x5, HI = 0x9. Result: bus_data = 0x5, bus_sel = 3, conflict = 1, conflict_cnt = 1.
  - Repeat for 300 cycles with CNTW = 8: counter saturates at 255.
- conflict_clr during conflict: conflict_clr = 1 together with a two-hot src_out. Next edge: conflict = 0, conflict_cnt = 0, and bus_data still updates.
- Parametrisation: N = 5, WIDTH = 8. Walk one-hot enables 0→4 with data 0x11·(i+1). Bus follows 1 cycle later, bus_sel = 0..4.
